// File: rtl/island_pkg.sv
// Shared definitions for the island extractor: FSM encoding, clog2 and derived widths.
// The optional sum path is enabled with the ISLAND_SUM_EN macro.
package island_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    localparam int DEF_BITS      = 31;
    localparam int DEF_LANES     = 4;
    localparam int DEF_LEN_BITS  = 16;
    localparam int DEF_MAX_BEATS = 4096;

    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

    // A lane index needs at least one bit even when there is a single lane.
    function automatic int lane_idx_bits(input int lanes);
        return (clog2(lanes) > 0) ? clog2(lanes) : 1;
    endfunction

    function automatic int peak_idx_bits(input int lanes, input int len_bits);
        return len_bits + clog2(lanes);
    endfunction

    function automatic int sum_bits(input int bits, input int lanes, input int len_bits);
        return bits + len_bits + clog2(lanes);
    endfunction

endpackage

// File: rtl/lane_reduce.sv
// Per-beat max/argmax (and sum when ISLAND_SUM_EN is defined) over LANES samples,
// as an input register followed by a registered pairwise tree: log2(LANES)+1 cycles.
module lane_reduce
    import island_pkg::*;
#(
    parameter int BITS  = DEF_BITS,
    parameter int LANES = DEF_LANES
) (
    input  logic                                clk,
    input  logic                                reset_n,
    input  logic [LANES*BITS-1:0]               samples,
    output logic signed [BITS-1:0]              beat_max,
    output logic [lane_idx_bits(LANES)-1:0]     beat_lane
`ifdef ISLAND_SUM_EN
    ,
    output logic signed [BITS+clog2(LANES)-1:0] beat_sum
`endif
);

    localparam int LG = clog2(LANES);
    localparam int LW = lane_idx_bits(LANES);
    localparam int SW = BITS + LG;

    for (genvar l = 0; l <= LG; l++) begin : lvl
        localparam int N = LANES >> l;

        logic signed [BITS-1:0] mx [N];
        logic [LW-1:0]          ix [N];
`ifdef ISLAND_SUM_EN
        logic signed [SW-1:0]   sm [N];
`endif

        if (l == 0) begin : g_in
            always_ff @(posedge clk) begin
                for (int n = 0; n < N; n++) begin
                    if (!reset_n) begin
                        mx[n] <= '0;
                        ix[n] <= '0;
                    end else begin
                        mx[n] <= samples[n*BITS +: BITS];
                        ix[n] <= LW'(n);
                    end
                end
            end
`ifdef ISLAND_SUM_EN
            always_ff @(posedge clk) begin
                for (int n = 0; n < N; n++) begin
                    if (!reset_n) begin
                        sm[n] <= '0;
                    end else begin
                        sm[n] <= SW'(signed'(samples[n*BITS +: BITS]));
                    end
                end
            end
`endif
        end else begin : g_node
            // The right (later) child wins only when strictly greater, so ties keep the earliest lane.
            always_ff @(posedge clk) begin
                for (int n = 0; n < N; n++) begin
                    if (!reset_n) begin
                        mx[n] <= '0;
                        ix[n] <= '0;
                    end else if (lvl[l-1].mx[2*n+1] > lvl[l-1].mx[2*n]) begin
                        mx[n] <= lvl[l-1].mx[2*n+1];
                        ix[n] <= lvl[l-1].ix[2*n+1];
                    end else begin
                        mx[n] <= lvl[l-1].mx[2*n];
                        ix[n] <= lvl[l-1].ix[2*n];
                    end
                end
            end
`ifdef ISLAND_SUM_EN
            always_ff @(posedge clk) begin
                for (int n = 0; n < N; n++) begin
                    if (!reset_n) begin
                        sm[n] <= '0;
                    end else begin
                        sm[n] <= lvl[l-1].sm[2*n] + lvl[l-1].sm[2*n+1];
                    end
                end
            end
`endif
        end
    end

    assign beat_max  = lvl[LG].mx[0];
    assign beat_lane = lvl[LG].ix[0];
`ifdef ISLAND_SUM_EN
    assign beat_sum  = lvl[LG].sm[0];
`endif

endmodule

// File: rtl/island_extractor.sv
// Tracks runs of triggered beats ("islands") and reports peak, peak index, length and sum.
// The sum accumulator and q_sum exist only when ISLAND_SUM_EN is defined; otherwise q_sum is 0.
module island_extractor
    import island_pkg::*;
#(
    parameter int BITS      = DEF_BITS,
    parameter int LANES     = DEF_LANES,
    parameter int LEN_BITS  = DEF_LEN_BITS,
    parameter int MAX_BEATS = DEF_MAX_BEATS
) (
    input  logic                                        clk,
    input  logic                                        reset_n,
    input  logic                                        trig,
    input  logic [LANES*BITS-1:0]                       samples,
    output logic                                        valid_out,
    output logic signed [BITS-1:0]                      q_peak,
    output logic [peak_idx_bits(LANES, LEN_BITS)-1:0]   peak_idx,
    output logic signed [sum_bits(BITS, LANES, LEN_BITS)-1:0] q_sum,
    output logic [LEN_BITS-1:0]                         island_len,
    output logic                                        forced
);

    localparam int LG    = clog2(LANES);
    localparam int LW    = lane_idx_bits(LANES);
    localparam int D     = LG + 1;
    localparam int IW    = peak_idx_bits(LANES, LEN_BITS);
    localparam int SUM_W = sum_bits(BITS, LANES, LEN_BITS);

    logic [D-1:0]           trig_pipe;
    logic                   beat_trig;
    logic signed [BITS-1:0] beat_max;
    logic [LW-1:0]          beat_lane;
    logic [IW-1:0]          beat_pos;

    state_t                 state, next_state;
    logic [LEN_BITS-1:0]    count, next_count;
    logic signed [BITS-1:0] acc_peak, next_peak;
    logic [IW-1:0]          acc_idx, next_idx;
    logic                   close, load;

    logic                   pend;
    logic signed [BITS-1:0] res_peak;
    logic [IW-1:0]          res_idx;
    logic [LEN_BITS-1:0]    res_len;
    logic                   res_forced;

`ifdef ISLAND_SUM_EN
    logic signed [BITS+LG-1:0] beat_sum;
    logic signed [SUM_W-1:0]   acc_sum, next_sum, res_sum;
`endif

    assign beat_trig = trig_pipe[D-1];
    assign beat_pos  = IW'(count) * IW'(LANES) + IW'(beat_lane);

    lane_reduce #(
        .BITS  (BITS),
        .LANES (LANES)
    ) u_reduce (
        .clk       (clk),
        .reset_n   (reset_n),
        .samples   (samples),
        .beat_max  (beat_max),
        .beat_lane (beat_lane)
`ifdef ISLAND_SUM_EN
        ,
        .beat_sum  (beat_sum)
`endif
    );

    // A close is only known one beat after the island's last beat; a triggered beat arriving
    // at a forced close immediately opens the next island so that no data is dropped.
    always_comb begin
        next_state = state;
        next_count = count;
        next_peak  = acc_peak;
        next_idx   = acc_idx;
        close      = 1'b0;
        load       = 1'b0;
`ifdef ISLAND_SUM_EN
        next_sum   = acc_sum;
`endif
        case (state)
            IDLE: begin
                load = beat_trig;
            end
            ACTIVE: begin
                if (beat_trig && count != LEN_BITS'(MAX_BEATS)) begin
                    next_count = count + LEN_BITS'(1);
                    if (beat_max > acc_peak) begin
                        next_peak = beat_max;
                        next_idx  = beat_pos;
                    end
`ifdef ISLAND_SUM_EN
                    next_sum = acc_sum + SUM_W'(beat_sum);
`endif
                end else begin
                    close      = 1'b1;
                    load       = beat_trig;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
        if (load) begin
            next_state = ACTIVE;
            next_count = LEN_BITS'(1);
            next_peak  = beat_max;
            next_idx   = IW'(beat_lane);
`ifdef ISLAND_SUM_EN
            next_sum   = SUM_W'(beat_sum);
`endif
        end
    end

    // Closed results wait one cycle in res_* before being published on the outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            trig_pipe  <= '0;
            state      <= IDLE;
            count      <= '0;
            acc_peak   <= '0;
            acc_idx    <= '0;
            pend       <= 1'b0;
            res_peak   <= '0;
            res_idx    <= '0;
            res_len    <= '0;
            res_forced <= 1'b0;
            valid_out  <= 1'b0;
            q_peak     <= '0;
            peak_idx   <= '0;
            island_len <= '0;
            forced     <= 1'b0;
        end else begin
            trig_pipe <= (trig_pipe << 1) | D'(trig);
            state     <= next_state;
            count     <= next_count;
            acc_peak  <= next_peak;
            acc_idx   <= next_idx;
            pend      <= close;
            if (close) begin
                res_peak   <= acc_peak;
                res_idx    <= acc_idx;
                res_len    <= count;
                res_forced <= beat_trig;
            end
            valid_out <= pend;
            if (pend) begin
                q_peak     <= res_peak;
                peak_idx   <= res_idx;
                island_len <= res_len;
                forced     <= res_forced;
            end
        end
    end

`ifdef ISLAND_SUM_EN
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            acc_sum <= '0;
            res_sum <= '0;
            q_sum   <= '0;
        end else begin
            acc_sum <= next_sum;
            if (close) begin
                res_sum <= acc_sum;
            end
            if (pend) begin
                q_sum <= res_sum;
            end
        end
    end
`else
    assign q_sum = '0;
`endif

endmodule
